// File: rtl/obf_sub_seq.sv
// obf_sub_seq: drives the obfuscation substitution LUT (index/ppc) and rebuilds
// one instruction word per LUT entry for decode. Fetch is held off until the
// entry carrying the last flag has been handed over.
// Optional feature macro: OBF_SEQ_IMM_EN (type-I entries consume a second
// LUT entry as a sign-extended immediate and advance ppc by 2).
module obf_sub_seq #(
  parameter int IGU_WIDTH     = 7,
  parameter int PPC_WIDTH     = 3,
  parameter int LUT_OUT_WIDTH = 16,
  parameter int INSN_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INSN_WIDTH-1:0]    in_insn,
  input  logic [IGU_WIDTH-1:0]     in_index,
  output logic [IGU_WIDTH-1:0]     lut_index,
  output logic [PPC_WIDTH-1:0]     lut_ppc,
  input  logic [LUT_OUT_WIDTH-1:0] lut_sub,
  input  logic [LUT_OUT_WIDTH-1:0] lut_imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INSN_WIDTH-1:0]    out_insn,
  output logic                     out_last,
  output logic                     seq_err
);

  localparam logic [PPC_WIDTH-1:0] PPC_MAX = '1;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                 r_state;
  logic [INSN_WIDTH-1:0]  r_insn;
  logic [IGU_WIDTH-1:0]   r_lut_index;
  logic [PPC_WIDTH-1:0]   r_lut_ppc;
  logic                   r_in_ready;
  logic                   r_out_valid;
  logic                   r_seq_err;

  logic [2:0]             w_type;
  logic [12:0]            w_p;
  logic [7:0]             w_f;
  logic [4:0]             w_rd, w_ra, w_rb;
  logic [15:0]            w_imm;
  logic                   w_last_flag;
  logic                   w_at_end;
  logic                   w_overrun;
  logic                   w_last;
  logic [PPC_WIDTH-1:0]   w_step;

  assign w_type = lut_sub[15:13];
  assign w_p    = lut_sub[12:0];
  assign w_f    = w_p[12:5];

  // Register fields rebuilt from the held instruction under the entry's selects
  assign w_rd = w_p[4] ? 5'd0 : r_insn[25:21];
  assign w_rb = w_p[1] ? 5'd0 : r_insn[15:11];
  always_comb begin
    w_ra = r_insn[20:16];
    case (w_p[3:2])
      2'b00:   w_ra = r_insn[20:16];
      2'b01:   w_ra = r_insn[15:11];
      2'b10:   w_ra = 5'd0;
      default: w_ra = r_insn[25:21];
    endcase
  end

`ifdef OBF_SEQ_IMM_EN
  // Type-I entries pull the immediate and the last flag from the following entry
  assign w_imm       = {{4{lut_imm[12]}}, lut_imm[12:1]};
  assign w_last_flag = (w_type == 3'b010) ? lut_imm[0] : w_p[0];
  assign w_step      = (w_type == 3'b010) ? PPC_WIDTH'(2) : PPC_WIDTH'(1);
  assign w_at_end    = (w_type == 3'b010) ? (r_lut_ppc >= PPC_MAX - 1'b1)
                                          : (r_lut_ppc == PPC_MAX);
`else
  logic w_unused_imm;
  assign w_unused_imm = ^lut_imm;
  assign w_imm        = 16'h0000;
  assign w_last_flag  = w_p[0];
  assign w_step       = PPC_WIDTH'(1);
  assign w_at_end     = (r_lut_ppc == PPC_MAX);
`endif

  // Running off the end of ppc space without a last flag ends the sequence anyway
  assign w_overrun = w_at_end & ~w_last_flag;
  assign w_last    = w_last_flag | w_overrun;

  // Word assembly by entry type; unknown types pass the instruction through
  always_comb begin
    out_insn = r_insn;
    case (w_type)
      3'b001:  out_insn = {6'h38, w_rd, w_ra, w_rb, 1'b0, w_f[7:4], 2'b00, w_f[3:0]};
      3'b010:  out_insn = {w_f[7:2], w_rd, w_ra, w_imm};
      default: out_insn = r_insn;
    endcase
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_valid & w_last;
  assign lut_index = r_lut_index;
  assign lut_ppc   = r_lut_ppc;
  assign seq_err   = r_seq_err;

  // Sequencer FSM: accept in IDLE, step through LUT entries in ISSUE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_insn      <= '0;
      r_lut_index <= '0;
      r_lut_ppc   <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_seq_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_in_ready <= 1'b1;
          if (in_valid && r_in_ready) begin
            r_insn      <= in_insn;
            r_lut_index <= in_index;
            r_lut_ppc   <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (out_ready) begin
            if (w_overrun) r_seq_err <= 1'b1;
            if (w_last) begin
              r_out_valid <= 1'b0;
              r_in_ready  <= 1'b1;
              r_state     <= IDLE;
            end else begin
              r_lut_ppc <= r_lut_ppc + w_step;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_obf_sub_seq.sv
// Scoreboard bench for obf_sub_seq: a LUT table model feeds lut_sub/lut_imm,
// a reference expands each accepted instruction into its expected word list,
// and a monitor compares every presented word against the queue head.
module tb_obf_sub_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_insn;
  logic [6:0]  in_index;
  logic [6:0]  lut_index;
  logic [2:0]  lut_ppc;
  logic [15:0] lut_sub;
  logic [15:0] lut_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_insn;
  logic        out_last;
  logic        seq_err;

  obf_sub_seq dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn), .in_index(in_index),
    .lut_index(lut_index), .lut_ppc(lut_ppc), .lut_sub(lut_sub), .lut_imm(lut_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_insn(out_insn),
    .out_last(out_last), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  // LUT model: one table, entries addressed by ppc
  logic [15:0] lut_mem [8];
  assign lut_sub = lut_mem[lut_ppc];
  assign lut_imm = lut_mem[3'(lut_ppc + 3'd1)];

  typedef struct {
    logic [31:0] insn;
    logic        last;
    logic [2:0]  ppc;
    logic [6:0]  idx;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  logic exp_err = 1'b0;
  int   hold_low = 0;
  bit   rand_rdy = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference word builder from the field rules, using plain arithmetic
  function automatic logic [31:0] model_word(input logic [31:0] insn,
                                             input logic [15:0] e,
                                             input logic [15:0] ie);
    int unsigned ty, p, f, rd, ra, rb, nd, na, nb, imm;
    ty = e >> 13;  p = e & 16'h1FFF;  f = p >> 5;
    rd = (insn >> 21) & 31;  ra = (insn >> 16) & 31;  rb = (insn >> 11) & 31;
    nd = ((p >> 4) & 1) ? 0 : rd;
    nb = ((p >> 1) & 1) ? 0 : rb;
    case ((p >> 2) & 3)
      0: na = ra;
      1: na = rb;
      2: na = 0;
      default: na = rd;
    endcase
    imm = 0;
`ifdef OBF_SEQ_IMM_EN
    imm = (ie >> 1) & 12'hFFF;
    if (imm >= 2048) imm = imm + 32'hF000;
    imm = imm & 16'hFFFF;
`else
    if (ie === 16'hxxxx) imm = 0;
`endif
    if (ty == 1)
      return 32'(32'h38 * 67108864 + nd * 2097152 + na * 65536 + nb * 2048
                 + ((f >> 4) & 15) * 64 + (f & 15));
    if (ty == 2)
      return 32'(((f >> 2) & 63) * 67108864 + nd * 2097152 + na * 65536 + imm);
    return insn;
  endfunction

  // Expand one instruction into its expected output stream
  task automatic push_seq(input logic [31:0] insn, input logic [6:0] idx);
    int   p = 0;
    int   step;
    logic lastf, atend, last;
    forever begin
      step  = 1;
      lastf = lut_mem[p][0];
      atend = (p == 7);
`ifdef OBF_SEQ_IMM_EN
      if (lut_mem[p][15:13] == 3'b010) begin
        step = 2; lastf = lut_mem[(p + 1) % 8][0]; atend = (p >= 6);
      end
`endif
      last = lastf || atend;
      if (atend && !lastf) exp_err = 1'b1;
      sb.push_back('{model_word(insn, lut_mem[p], lut_mem[(p + 1) % 8]), last, 3'(p), idx});
      if (last) break;
      p += step;
    end
  endtask

  // out_ready driver: forced-low window, random, or always ready
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (hold_low > 0) begin out_ready = 1'b0; hold_low--; end
      else out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compare presented word against the queue head, pop on handshake
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (sb.size() == 0) chk("unexpected_word", {32'h0, out_insn}, 64'hDEAD);
        else begin
          e = sb[0];
          chk("out_insn", {32'h0, out_insn}, {32'h0, e.insn});
          chk("out_last", {63'h0, out_last}, {63'h0, e.last});
          chk("lut_ppc",  {61'h0, lut_ppc},  {61'h0, e.ppc});
          chk("lut_index", {57'h0, lut_index}, {57'h0, e.idx});
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic start_seq(input logic [31:0] insn, input logic [6:0] idx);
    int k = 0;
    @(negedge clk);
    while (!in_ready && k < 50) begin @(negedge clk); k++; end
    if (!in_ready) chk("in_ready_timeout", 64'h0, 64'h1);
    in_insn = insn; in_index = idx; in_valid = 1'b1;
    push_seq(insn, idx);
    @(negedge clk);
    in_valid = 1'b0;
    chk("first_word_latency", {63'h0, out_valid}, 64'h1);
  endtask

  task automatic wait_done(output int n);
    int k = 0;
    n = 1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++; k++;
      if (k > 300) begin chk("done_timeout", 64'h0, 64'h1); break; end
    end
    chk("sb_drained", 64'(sb.size()), 64'h0);
    chk("seq_err", {63'h0, seq_err}, {63'h0, exp_err});
  endtask

  task automatic load_tbl3();
    lut_mem[0] = {3'b010, 13'h1A2C};
    lut_mem[1] = {3'b001, 13'h0F96};
    lut_mem[2] = {3'b001, 13'h0A5B};
    for (int i = 3; i < 8; i++) lut_mem[i] = 16'h0000;
  endtask

  initial begin
    int n, k;
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k;
    rst = 1'b1; in_valid = 1'b0; in_insn = '0; in_index = '0;
    for (int i = 0; i < 8; i++) lut_mem[i] = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  {63'h0, in_ready},  64'h0);
    chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_out_last",  {63'h0, out_last},  64'h0);
    chk("rst_lut_ppc",   {61'h0, lut_ppc},   64'h0);
    chk("rst_lut_index", {57'h0, lut_index}, 64'h0);
    chk("rst_seq_err",   {63'h0, seq_err},   64'h0);
    rst = 1'b0;
    #1 chk("in_ready_before_clk", {63'h0, in_ready}, 64'h0);
    @(negedge clk);
    chk("in_ready_after_clk", {63'h0, in_ready}, 64'h1);

    // Three-entry I, A, A-last sequence, decode always ready
    load_tbl3();
    start_seq(32'hE0632000, 7'd64);
    wait_done(n);
`ifndef OBF_SEQ_IMM_EN
    chk("three_word_cycles", 64'(n), 64'd3);
`endif

    // Single type-N entry with last set
    lut_mem[0] = {3'b000, 13'h0001};
    start_seq(32'h12345678, 7'd5);
    wait_done(n);
    chk("single_word_cycles", 64'(n), 64'd1);

    // Decode stalls for 5 cycles mid-sequence
    load_tbl3();
    start_seq(32'hE0632000, 7'd17);
    hold_low = 5;
    wait_done(n);
`ifndef OBF_SEQ_IMM_EN
    chk("stall_cycles", 64'(n), 64'd8);
`endif

    // No last flag anywhere: overrun after 8 words, seq_err becomes sticky
    for (int i = 0; i < 8; i++) lut_mem[i] = {3'(i % 2), 13'h0F3C};
    start_seq(32'hA5A5F0F0, 7'd99);
    wait_done(n);
    chk("overrun_cycles", 64'(n), 64'd8);
    chk("seq_err_set", {63'h0, seq_err}, 64'h1);
    lut_mem[0] = {3'b000, 13'h0001};
    start_seq(32'h0BADF00D, 7'd3);
    wait_done(n);
    chk("seq_err_sticky", {63'h0, seq_err}, 64'h1);

`ifdef OBF_SEQ_IMM_EN
    // Type-I entry with an all-ones immediate entry carrying the last flag
    lut_mem[0] = {3'b010, 13'h1F00};
    lut_mem[1] = {3'b000, 12'hFFF, 1'b1};
    start_seq(32'hE0632000, 7'd8);
    wait_done(n);
    chk("imm_single_word", 64'(n), 64'd1);
`endif

    // Asynchronous reset while lut_ppc=2
    for (int i = 0; i < 8; i++) lut_mem[i] = {3'b001, 13'h0550};
    start_seq(32'h87654321, 7'd42);
    k = 0;
    while (lut_ppc != 3'd2 && k < 20) begin @(negedge clk); k++; end
    chk("reach_ppc2", {61'h0, lut_ppc}, 64'd2);
    #3 rst = 1'b1;
    #1;
    chk("arst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("arst_lut_ppc",   {61'h0, lut_ppc},   64'h0);
    chk("arst_seq_err",   {63'h0, seq_err},   64'h0);
    chk("arst_in_ready",  {63'h0, in_ready},  64'h0);
    sb.delete();
    exp_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    load_tbl3();
    start_seq(32'hE0632000, 7'd64);
    wait_done(n);

    // Random instructions, tables and decode back-pressure
    rand_rdy = 1'b1;
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < 8; i++)
        lut_mem[i] = {3'($urandom_range(0, 7)), 12'($urandom), 1'($urandom_range(0, 3) == 0)};
      start_seq($urandom, 7'($urandom));
      wait_done(n);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/obf_sub_seq.md
Name: obf_sub_seq

Overview:
- Sequencer that drives the obfuscation substitution LUT and consumes its entries.
- Accepts one decoded instruction from fetch, sets the LUT `index`, steps `ppc` through the substitution sequence, and emits one rebuilt instruction word per entry to decode.
- Holds fetch off with a valid/ready handshake until the entry carrying the last flag has been issued.

Parameters:
- IGU_WIDTH, 7, width of the instruction-group index sent to the LUT.
- PPC_WIDTH, 3, width of the sequence position counter.
- LUT_OUT_WIDTH, 16, LUT entry width: [15:13] type, [12:0] payload.
- INSN_WIDTH, 32, instruction word width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  sequencer accepts the instruction this cycle
- in_insn  in  INSN_WIDTH  original instruction
- in_index  in  IGU_WIDTH  instruction-group index from the classifier
- lut_index  out  IGU_WIDTH  index to the LUT (registered)
- lut_ppc  out  PPC_WIDTH  sequence position to the LUT (registered)
- lut_sub  in  LUT_OUT_WIDTH  LUT entry at lut_ppc
- lut_imm  in  LUT_OUT_WIDTH  LUT entry at lut_ppc+1
- out_valid  out  1  substituted instruction valid
- out_ready  in  1  decode accepts
- out_insn  out  INSN_WIDTH  substituted instruction
- out_last  out  1  this is the final word of the sequence
- seq_err  out  1  sticky: sequence overran without a last flag

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_last=0, lut_ppc=0, lut_index=0, seq_err=0, held insn=0, state=IDLE. in_ready goes to 1 on the first clock after rst deasserts.
- States: IDLE, ISSUE.
- IDLE: in_ready=1, out_valid=0.
  - On in_valid&in_ready: latch in_insn, lut_index<=in_index, lut_ppc<=0, go to ISSUE.
  - First word is valid the cycle after acceptance (1-cycle latency).
- ISSUE: in_ready=0, out_valid=1; out_insn/out_last are combinational from the held insn and lut_sub.
  - out_valid && !out_ready: all outputs and lut_ppc hold stable.
  - On out_ready with P[0]=1 (last): go to IDLE. The next instruction is accepted no earlier than the following cycle, so there is no back-to-back accept in the same cycle.
  - On out_ready with P[0]=0: lut_ppc<=lut_ppc+1, stay in ISSUE.
  - Overrun: if lut_ppc is at all-ones and P[0]=0, out_last is forced to 1, seq_err is set, and the block returns to IDLE after the handshake. lut_ppc never wraps to 0 within a sequence.
- Payload fields, P=lut_sub[12:0]:
  - F=P[12:5], opcode field.
  - P[4]: rD zero-select.
  - P[3:2]: rA select (00 original rA, 01 original rB, 10 r0, 11 original rD).
  - P[1]: rB zero-select.
  - P[0]: last flag.
- Type codes, lut_sub[15:13]: 000 N, 001 A, 010 I; any other code is treated as N.
- Word assembly by type:
  - N: out_insn = held insn unchanged.
  - A: [31:26]=6'h38; rD[25:21], rA[20:16], rB[15:11] per the selects; [10]=0; [9:6]=F[7:4]; [5:4]=0; [3:0]=F[3:0].
  - I: [31:26]=F[7:2]; rD, rA per the selects; [15:0]=immediate (see Optional Feature).
- Original register fields are taken from the held insn: rD=[25:21], rA=[20:16], rB=[15:11].
- out_last = P[0] OR the overrun condition.
- seq_err clears only on rst.
- rst asserted mid-sequence: immediate return to reset values, and the partial sequence is discarded.

Optional Feature:
- OBF_SEQ_IMM_EN defined:
  - A type-I entry takes its immediate from lut_imm[12:1] sign-extended to 16 bits.
  - The handshake advances lut_ppc by 2, consuming the immediate entry.
  - The last flag is taken from lut_imm[0].
  - The overrun check uses lut_ppc >= all-ones minus 1.
- Not defined: the immediate is 16'h0000, lut_imm is ignored, and lut_ppc always steps by 1.

Test Plan:
- Reset release, then in_insn=32'hE0632000 (rD=3, rA=3, rB=4), in_index=64, LUT returns a 3-entry sequence (I, A, A-last), out_ready=1 -> three words on consecutive cycles with lut_ppc 0,1,2; out_last only on the third; in_ready=1 the cycle after.
- Type-N single entry, payload 13'h0001 -> out_insn equals in_insn, out_last=1, one word only.
- out_ready held low 5 cycles during ISSUE -> out_insn, lut_ppc and out_valid stable throughout; progress resumes on the first out_ready=1.
- LUT never sets the last flag, PPC_WIDTH=3 -> 8 words issued; the 8th has out_last=1; seq_err=1 and stays 1 through later sequences until rst.
- rst pulsed while lut_ppc=2 -> out_valid=0 and lut_ppc=0 immediately (asynchronous); after release a new instruction is accepted.
- OBF_SEQ_IMM_EN: type-I entry with lut_imm payload 12'hFFF/last -> immediate 16'hFFFF, lut_ppc advances by 2, sequence ends.
